// File: rtl/dec3_8_pulse.sv
// dec3_8_pulse: turns an encoded event (3-bit index + "line active" flag)
// back into a one-hot pulse of PULSE_LEN cycles followed by a one-cycle gap.
// A valid/ready handshake applies back-pressure while a pulse is running.
// Also keeps a sticky history of pulsed indices and a saturating count of
// accepted null events.
module dec3_8_pulse #(
    parameter int PULSE_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_code,
    input  logic             in_en,
    output logic [7:0]       out_onehot,
    output logic             out_active,
    output logic [7:0]       seen,
    input  logic             seen_clr,
    output logic [CNT_W-1:0] null_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Counter reload: DRIVE lasts from the load value down to zero inclusive.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] NULL_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       code_q, code_d;
    logic [7:0]       seen_q, seen_d;
    logic [CNT_W-1:0] null_q, null_d;
    logic             accept;

    // Ready is a pure decode of the registered state, so there is no
    // combinational path from in_valid back to in_ready.
    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;

    // Next-state, counter, latched code and null-count logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        null_d  = null_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_en) begin
                        code_d  = in_code;
                        cnt_d   = LOAD_VAL;
                        state_d = DRIVE;
                    end else if (null_q != NULL_MAX) begin
                        null_d = null_q + CNT_W'(1);
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-line decode: the pulse output is driven only from the latched
    // code, and a fresh accept on a bit overrides a same-edge clear.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_line
            assign out_onehot[gi] = (state_q == DRIVE) && (code_q == 3'(gi));
            assign seen_d[gi]     = (accept & in_en & (in_code == 3'(gi)))
                                  | (seen_q[gi] & ~seen_clr);
        end
    endgenerate

    assign out_active = (state_q == DRIVE);
    assign seen       = seen_q;
    assign null_cnt   = null_q;

    // State registers; reset abandons any pulse in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            seen_q  <= '0;
            null_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            seen_q  <= seen_d;
            null_q  <= null_d;
        end
    end

endmodule

// File: tb/tb_dec3_8_pulse.sv
// Testbench for dec3_8_pulse: table of per-cycle vectors with expected
// outputs after each rising edge, pushed to a scoreboard queue when driven
// and popped when the outputs are sampled 1 ns after the edge.
module tb_dec3_8_pulse;

    localparam int PULSE_LEN = 4;
    localparam int CNT_W     = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_code;
    logic             in_en;
    logic [7:0]       out_onehot;
    logic             out_active;
    logic [7:0]       seen;
    logic             seen_clr;
    logic [CNT_W-1:0] null_cnt;

    dec3_8_pulse #(
        .PULSE_LEN(PULSE_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_en     (in_en),
        .out_onehot(out_onehot),
        .out_active(out_active),
        .seen      (seen),
        .seen_clr  (seen_clr),
        .null_cnt  (null_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic       en;
        logic [2:0] code;
        logic       clr;
        logic [7:0] e_hot;
        logic       e_act;
        logic       e_rdy;
        logic [7:0] e_seen;
        logic [7:0] e_null;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    function automatic vec_t mk(logic valid, logic en, logic [2:0] code, logic clr,
                                logic [7:0] hot, logic act, logic rdy,
                                logic [7:0] sn, logic [7:0] nl);
        vec_t v;
        v.valid = valid; v.en = en; v.code = code; v.clr = clr;
        v.e_hot = hot; v.e_act = act; v.e_rdy = rdy; v.e_seen = sn; v.e_null = nl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (txn %0d)", name, act, req, txn);
        end
    endtask

    // Drive one cycle of stimulus, then compare against the queued expectation.
    task automatic apply(input vec_t v);
        vec_t e;
        in_valid = v.valid;
        in_en    = v.en;
        in_code  = v.code;
        seen_clr = v.clr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: v=%0b en=%0b code=%0d clr=%0b -> hot=%02h act=%0b rdy=%0b seen=%02h null=%0d",
                 txn, e.valid, e.en, e.code, e.clr, out_onehot, out_active, in_ready, seen, null_cnt);
        chk("onehot", 32'(out_onehot), 32'(e.e_hot));
        chk("active", 32'(out_active), 32'(e.e_act));
        chk("ready",  32'(in_ready),   32'(e.e_rdy));
        chk("seen",   32'(seen),       32'(e.e_seen));
        chk("null",   32'(null_cnt),   32'(e.e_null));
        chk("not_multihot", 32'($countones(out_onehot) <= 1), 32'd1);
    endtask

    // One full line pulse: accept, remaining drive cycles, gap, back to idle.
    task automatic pulse(input logic [2:0] c, input logic clr, input logic [7:0] sn,
                         input logic [7:0] nl);
        logic [7:0] hot;
        hot = 8'd1 << c;
        apply(mk(1'b1, 1'b1, c, clr, hot, 1'b1, 1'b0, sn, nl));
        for (int i = 1; i < PULSE_LEN; i++)
            apply(mk(1'b0, 1'b0, 3'd0, 1'b0, hot, 1'b1, 1'b0, sn, nl));
        apply(mk(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, sn, nl));
        apply(mk(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, sn, nl));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seen_acc;
        logic [7:0] hot;
        logic [7:0] nexp;

        // Single code-5 pulse right after reset.
        tbl.push_back(mk(1, 1, 3'd5, 0, 8'h20, 1, 0, 8'h20, 8'd0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 8'h20, 1, 0, 8'h20, 8'd0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 8'h20, 1, 0, 8'h20, 8'd0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 8'h20, 1, 0, 8'h20, 8'd0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 8'h00, 0, 0, 8'h20, 8'd0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 8'h00, 0, 1, 8'h20, 8'd0));
        // in_valid held high stepping codes 0..7; codes offered while busy
        // differ from the accepted one and must not be taken.
        seen_acc = 8'h20;
        for (int c = 0; c < 8; c++) begin
            hot = 8'd1 << c;
            seen_acc = seen_acc | hot;
            tbl.push_back(mk(1, 1, 3'(c),     0, hot,   1, 0, seen_acc, 8'd0));
            tbl.push_back(mk(1, 1, 3'(c + 3), 0, hot,   1, 0, seen_acc, 8'd0));
            tbl.push_back(mk(1, 1, 3'(c + 3), 0, hot,   1, 0, seen_acc, 8'd0));
            tbl.push_back(mk(1, 1, 3'(c + 3), 0, hot,   1, 0, seen_acc, 8'd0));
            tbl.push_back(mk(1, 1, 3'(c + 5), 0, 8'h00, 0, 0, seen_acc, 8'd0));
            tbl.push_back(mk(1, 1, 3'(c + 6), 0, 8'h00, 0, 1, seen_acc, 8'd0));
        end

        in_valid = 0; in_en = 0; in_code = 0; seen_clr = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_onehot", 32'(out_onehot), 32'h00);
        chk("rst_active", 32'(out_active), 32'h0);
        chk("rst_ready",  32'(in_ready),   32'h1);
        chk("rst_seen",   32'(seen),       32'h00);
        chk("rst_null",   32'(null_cnt),   32'h0);
        rst_n = 1;

        foreach (tbl[i]) apply(tbl[i]);

        // Back-to-back null events saturate the counter.
        for (int i = 0; i < 300; i++) begin
            nexp = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            apply(mk(1, 0, 3'($urandom_range(0, 7)), 0, 8'h00, 0, 1, 8'hFF, nexp));
        end

        // Code changes during DRIVE do not disturb the latched pulse.
        apply(mk(1, 1, 3'd3, 0, 8'h08, 1, 0, 8'hFF, 8'd255));
        for (int i = 0; i < 3; i++)
            apply(mk(1, 1, 3'd6, 0, 8'h08, 1, 0, 8'hFF, 8'd255));
        apply(mk(1, 1, 3'd6, 0, 8'h00, 0, 0, 8'hFF, 8'd255));
        apply(mk(1, 1, 3'd6, 0, 8'h00, 0, 1, 8'hFF, 8'd255));

        // Plain clear, rebuild seen=0F, then clear on the same edge as accept of 7.
        apply(mk(0, 0, 3'd0, 1, 8'h00, 0, 1, 8'h00, 8'd255));
        seen_acc = 8'h00;
        for (int c = 0; c < 4; c++) begin
            seen_acc = seen_acc | (8'd1 << c);
            pulse(3'(c), 1'b0, seen_acc, 8'd255);
        end
        pulse(3'd7, 1'b1, 8'h80, 8'd255);

        // Asynchronous reset in the 2nd DRIVE cycle of a code-2 pulse.
        apply(mk(1, 1, 3'd2, 0, 8'h04, 1, 0, 8'h84, 8'd255));
        apply(mk(0, 0, 3'd0, 0, 8'h04, 1, 0, 8'h84, 8'd255));
        #1;
        rst_n = 0;
        #1;
        chk("arst_onehot", 32'(out_onehot), 32'h00);
        chk("arst_active", 32'(out_active), 32'h0);
        chk("arst_ready",  32'(in_ready),   32'h1);
        chk("arst_seen",   32'(seen),       32'h00);
        chk("arst_null",   32'(null_cnt),   32'h0);
        @(negedge clk);
        rst_n = 1;
        pulse(3'd1, 1'b0, 8'h02, 8'd0);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
